// File: rtl/mii_mac_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : mii_mac_pkg
// Purpose  : Shared types and constants for the RTL8201 transmit-only MII MAC.
//            Contents: the transmit state enum, the MII nibble constants and
//            the IEEE 802.3 CRC-32 constants (reflected form).
// Revision : 1.0 - initial release
// ============================================================================
package mii_mac_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_LOAD = 4'd1,
        ST_PRE  = 4'd2,
        ST_SFD  = 4'd3,
        ST_DATA = 4'd4,
        ST_PAD  = 4'd5,
        ST_FCS  = 4'd6,
        ST_IFG  = 4'd7
    } state_t;

    localparam logic [3:0]  PRE_NIBBLE  = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE  = 4'hD;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    // Good-frame residue in normal (non-reflected) bit order.
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

endpackage : mii_mac_pkg
`default_nettype wire

// File: rtl/crc32_d4.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : crc32_d4
// Purpose  : Combinational CRC-32 next-state function, 4 data bits per step,
//            reflected (LSB-first) form as used on the MII nibble bus.
// Ports    : crc_in  [31:0] current CRC register
//            nibble  [3:0]  data nibble, bit 0 is the first bit on the wire
//            crc_out [31:0] CRC register after absorbing the nibble
// Revision : 1.0 - initial release
// ============================================================================
module crc32_d4
    import mii_mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nibble,
    output logic [31:0] crc_out
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = crc_in ^ {28'h0, nibble};
        for (int k = 0; k < 4; k++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC_POLY) : (w_crc >> 1);
        end
        crc_out = w_crc;
    end

endmodule : crc32_d4
`default_nettype wire

// File: rtl/rtl8201_mii_mac.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : rtl8201_mii_mac
// Purpose  : Transmit-only 100 Mb/s MII MAC for the RTL8201 PHY. Bytes are
//            captured at CLK rate into a frame buffer; when SEND_EN drops the
//            frame is sent as preamble, SFD, data, zero pad to MIN_LEN, FCS.
// Ports    : CLK, RST (async active-low)
//            SEND_DATA[7:0], SEND_EN   - byte stream / frame envelope in
//            SENT_BUSY                 - capture or transmission in progress
//            ETH_TX_CLK                - PHY TX clock, sampled as data
//            ETH_TX_EN, ETH_TX_DATA[3:0], ETH_RST_N - MII transmit side
//            ETH_RX_*, ETH_CRS         - routed through, unused
// Revision : 1.0 - initial release
// ============================================================================
module rtl8201_mii_mac
    import mii_mac_pkg::*;
#(
    parameter int BUF_DEPTH = 2048,
    parameter int MIN_LEN   = 60,
    parameter int PRE_NIB   = 15,
    parameter int IFG_NIB   = 24
)(
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SEND_DATA,
    input  logic       SEND_EN,
    output logic       SENT_BUSY,
    input  logic       ETH_TX_CLK,
    output logic       ETH_TX_EN,
    output logic [3:0] ETH_TX_DATA,
    output logic       ETH_RST_N,
    input  logic       ETH_RX_DV,
    input  logic       ETH_RX_ER,
    input  logic       ETH_RX_CLK,
    input  logic       ETH_CRS,
    input  logic [3:0] ETH_RX_DATA
);

    localparam int ADDR_W = $clog2(BUF_DEPTH);
    localparam int LEN_W  = ADDR_W + 1;   // must hold BUF_DEPTH itself
    localparam int CNT_W  = 8;

    // RX side of the PHY is not used by this MAC.
    logic w_unused;
    assign w_unused = &{1'b0, ETH_RX_DV, ETH_RX_ER, ETH_RX_CLK, ETH_CRS, ETH_RX_DATA};

    // ------------------------------------------------------------------
    // PHY reset follows the system reset, delayed by one registered stage.
    // ------------------------------------------------------------------
    logic r_rst_n;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_rst_n <= 1'b0;
        else      r_rst_n <= 1'b1;
    end
    assign ETH_RST_N = r_rst_n;

    // ------------------------------------------------------------------
    // TX clock synchronizer; a falling edge marks the start of a nibble
    // period, leaving half a TX_CLK period of setup before the PHY samples.
    // ------------------------------------------------------------------
    logic r_txc_s1, r_txc_s2, r_txc_s3;
    logic w_nib_stb;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_txc_s1 <= 1'b0;
            r_txc_s2 <= 1'b0;
            r_txc_s3 <= 1'b0;
        end else begin
            r_txc_s1 <= ETH_TX_CLK;
            r_txc_s2 <= r_txc_s1;
            r_txc_s3 <= r_txc_s2;
        end
    end
    assign w_nib_stb = r_txc_s3 & ~r_txc_s2;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state, w_state_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_byte_idx, w_byte_idx_next;
    logic               r_hi, w_hi_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [31:0]        r_crc, w_crc_next;
    logic               r_tx_en, w_tx_en_next;
    logic [3:0]         r_tx_data, w_tx_data_next;
    logic               r_busy;

    // ------------------------------------------------------------------
    // Frame buffer: one write port (capture), one registered read port.
    // The read address moves on a strobe and the data settles on the next
    // CLK edge, well before the following strobe (>= 2 CLKs away).
    // ------------------------------------------------------------------
    logic [7:0]        r_mem [BUF_DEPTH];
    logic [7:0]        r_rd_data;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_wr_en   = SEND_EN && (r_state == ST_IDLE || r_state == ST_LOAD)
                       && (r_len < LEN_W'(BUF_DEPTH));
    assign w_rd_addr = r_byte_idx[ADDR_W-1:0];

    always_ff @(posedge CLK) begin
        if (w_wr_en) r_mem[r_len[ADDR_W-1:0]] <= SEND_DATA;
        r_rd_data <= r_mem[w_rd_addr];
    end

    // ------------------------------------------------------------------
    // CRC over the nibble being sent (pad nibbles are zero).
    // ------------------------------------------------------------------
    logic [3:0]  w_nib;
    logic [31:0] w_crc_upd;

    assign w_nib = (r_state == ST_PAD) ? 4'h0
                 : (r_hi ? r_rd_data[7:4] : r_rd_data[3:0]);

    crc32_d4 u_crc (
        .crc_in  (r_crc),
        .nibble  (w_nib),
        .crc_out (w_crc_upd)
    );

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_byte_idx_next = r_byte_idx;
        w_hi_next       = r_hi;
        w_cnt_next      = r_cnt;
        w_crc_next      = r_crc;
        w_tx_en_next    = r_tx_en;
        w_tx_data_next  = r_tx_data;

        case (r_state)
            ST_IDLE: begin
                w_byte_idx_next = '0;
                w_hi_next       = 1'b0;
                w_cnt_next      = '0;
                w_crc_next      = CRC_INIT;
                if (SEND_EN) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (!SEND_EN) w_state_next = ST_PRE;
            end
            ST_PRE: begin
                if (w_nib_stb) begin
                    w_tx_en_next   = 1'b1;
                    w_tx_data_next = PRE_NIBBLE;
                    if (r_cnt == CNT_W'(PRE_NIB - 1)) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_SFD;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            ST_SFD: begin
                if (w_nib_stb) begin
                    w_tx_en_next   = 1'b1;
                    w_tx_data_next = SFD_NIBBLE;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA, ST_PAD: begin
                if (w_nib_stb) begin
                    w_tx_en_next   = 1'b1;
                    w_tx_data_next = w_nib;
                    w_crc_next     = w_crc_upd;
                    w_hi_next      = ~r_hi;
                    if (r_hi) begin
                        w_byte_idx_next = r_byte_idx + 1'b1;
                        if (r_state == ST_DATA) begin
                            if (r_byte_idx + 1'b1 == r_len)
                                w_state_next = (r_len < LEN_W'(MIN_LEN)) ? ST_PAD : ST_FCS;
                        end else if (r_byte_idx + 1'b1 == LEN_W'(MIN_LEN)) begin
                            w_state_next = ST_FCS;
                        end
                    end
                end
            end
            ST_FCS: begin
                // Complemented CRC, least-significant nibble first.
                if (w_nib_stb) begin
                    w_tx_en_next   = 1'b1;
                    w_tx_data_next = ~r_crc[3:0];
                    w_crc_next     = {4'h0, r_crc[31:4]};
                    if (r_cnt == CNT_W'(7)) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_IFG;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            ST_IFG: begin
                // Strobe 0 drops TX_EN; strobe IFG_NIB closes the gap.
                if (w_nib_stb) begin
                    w_tx_en_next   = 1'b0;
                    w_tx_data_next = 4'h0;
                    if (r_cnt == CNT_W'(IFG_NIB)) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_tx_en_next   = 1'b0;
                w_tx_data_next = 4'h0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_byte_idx <= '0;
            r_hi       <= 1'b0;
            r_cnt      <= '0;
            r_crc      <= CRC_INIT;
            r_tx_en    <= 1'b0;
            r_tx_data  <= 4'h0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_byte_idx <= w_byte_idx_next;
            r_hi       <= w_hi_next;
            r_cnt      <= w_cnt_next;
            r_crc      <= w_crc_next;
            r_tx_en    <= w_tx_en_next;
            r_tx_data  <= w_tx_data_next;
            r_busy     <= (w_state_next != ST_IDLE);
        end
    end

    // Length saturates at BUF_DEPTH; cleared once the gap has elapsed.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            r_len <= '0;
        else if (w_wr_en)
            r_len <= r_len + 1'b1;
        else if (r_state == ST_IFG && w_state_next == ST_IDLE)
            r_len <= '0;
    end

    assign ETH_TX_EN   = r_tx_en;
    assign ETH_TX_DATA = r_tx_data;
    assign SENT_BUSY   = r_busy;

endmodule : rtl8201_mii_mac
`default_nettype wire

// File: tb/tb_rtl8201_mii_mac.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_rtl8201_mii_mac
// Purpose  : Self-checking bench for rtl8201_mii_mac. Frames are listed in a
//            vector table with hand-computed wire lengths; the wire is
//            captured on ETH_TX_CLK rising edges like the PHY would.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtl8201_mii_mac;
    import mii_mac_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] SEND_DATA = 8'h00;
    logic       SEND_EN = 1'b0;
    logic       SENT_BUSY;
    logic       ETH_TX_CLK = 1'b0;
    logic       ETH_TX_EN;
    logic [3:0] ETH_TX_DATA;
    logic       ETH_RST_N;

    rtl8201_mii_mac dut (
        .CLK         (CLK),
        .RST         (RST),
        .SEND_DATA   (SEND_DATA),
        .SEND_EN     (SEND_EN),
        .SENT_BUSY   (SENT_BUSY),
        .ETH_TX_CLK  (ETH_TX_CLK),
        .ETH_TX_EN   (ETH_TX_EN),
        .ETH_TX_DATA (ETH_TX_DATA),
        .ETH_RST_N   (ETH_RST_N),
        .ETH_RX_DV   (1'b0),
        .ETH_RX_ER   (1'b0),
        .ETH_RX_CLK  (1'b0),
        .ETH_CRS     (1'b0),
        .ETH_RX_DATA (4'h0)
    );

    always #10 CLK = ~CLK;                 // 50 MHz, rising at 10 + 20k
    initial begin
        #5;
        forever #20 ETH_TX_CLK = ~ETH_TX_CLK;  // 25 MHz, rising at 25 + 40k
    end

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Wire monitor (PHY view)
    // ------------------------------------------------------------------
    logic [3:0] q_nib[$];
    int  frames = 0;
    int  ifg_cnt = 0;
    int  idle_bad = 0;
    bit  in_frame = 0;
    bit  prev_en = 0;

    always @(posedge ETH_TX_CLK) begin
        if (ETH_TX_EN) begin
            q_nib.push_back(ETH_TX_DATA);
            if (!prev_en) begin
                frames++;
                ifg_cnt = 0;
            end
            in_frame = 1;
        end else begin
            if (ETH_TX_DATA !== 4'h0) idle_bad++;
            if (in_frame && SENT_BUSY) ifg_cnt++;
            if (!SENT_BUSY) in_frame = 0;
        end
        prev_en = ETH_TX_EN;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [7:0] byte_of(input int kind, input int i);
        logic [7:0] b;
        case (kind)
            0: case (i)
                   0: b = 8'h00;  1: b = 8'h11;  2: b = 8'h22;  3: b = 8'h33;
                   4: b = 8'h44;  5: b = 8'h55;  6: b = 8'h66;  7: b = 8'h00;
                   8: b = 8'h0A;  9: b = 8'h35; 10: b = 8'h01; 11: b = 8'hFE;
                  12: b = 8'hC0; 57: b = 8'h08; 58: b = 8'h06; 59: b = 8'h00;
                  60: b = 8'h01;
                  default: b = 8'(i);
               endcase
            1: b = 8'h31 + 8'(i);          // "123456789"
            2: b = 8'hA5;
            default: b = 8'(i) ^ 8'h3C;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    typedef struct {
        int kind;
        int len;
        int exp_nib;    // hand-computed TX_EN-high nibble count
    } vec_t;

    // ------------------------------------------------------------------
    // Send one frame and check everything seen on the wire.
    // ------------------------------------------------------------------
    task automatic run_frame(input string tag, input int kind, input int len,
                             input int exp_nib, input bit pulse_mid);
        int          n_cap, n_dat, bad, c;
        logic [7:0]  exp_b [$];
        logic [31:0] crc, fcs_w, r, rev;
        logic [7:0]  wb;

        q_nib.delete();
        frames = 0;
        idle_bad = 0;

        for (int i = 0; i < len; i++) begin
            @(posedge CLK); #1;
            SEND_EN = 1'b1;
            SEND_DATA = byte_of(kind, i);
        end
        @(posedge CLK); #1;
        SEND_EN = 1'b0;
        SEND_DATA = 8'h00;

        if (pulse_mid) begin
            c = 0;
            while (q_nib.size() < 40 && c < 2000) begin @(posedge CLK); c++; end
            check({tag, "_mid_reach"}, (q_nib.size() >= 40), 1);
            @(posedge CLK); #1; SEND_EN = 1'b1; SEND_DATA = 8'hFF;
            repeat (3) @(posedge CLK);
            #1; SEND_EN = 1'b0; SEND_DATA = 8'h00;
        end

        c = 0;
        while (SENT_BUSY && c < 30000) begin @(posedge CLK); c++; end
        check({tag, "_busy_done"}, SENT_BUSY, 0);
        repeat (200) @(posedge CLK);

        // Model: captured bytes (saturating) then zero pad.
        n_cap = (len > 2048) ? 2048 : len;
        for (int i = 0; i < n_cap; i++) exp_b.push_back(byte_of(kind, i));
        while (exp_b.size() < 60) exp_b.push_back(8'h00);
        n_dat = exp_b.size();

        check({tag, "_nibbles"}, q_nib.size(), exp_nib);
        check({tag, "_frames"}, frames, 1);

        bad = 0;
        for (int i = 0; i < 15; i++) if (q_nib[i] !== 4'h5) bad++;
        if (q_nib[15] !== 4'hD) bad++;
        check({tag, "_preamble_bad"}, bad, 0);

        bad = 0;
        for (int i = 0; i < 2 * n_dat; i++) begin
            wb = exp_b[i / 2];
            if (q_nib[16 + i] !== ((i % 2) ? wb[7:4] : wb[3:0])) bad++;
        end
        check({tag, "_data_bad"}, bad, 0);

        crc = 32'hFFFFFFFF;
        foreach (exp_b[i]) crc = crc_byte(crc, exp_b[i]);
        fcs_w = '0;
        for (int k = 0; k < 8; k++) fcs_w[4 * k +: 4] = q_nib[16 + 2 * n_dat + k];
        check({tag, "_fcs"}, fcs_w, ~crc);

        r = 32'hFFFFFFFF;
        for (int i = 0; i < n_dat + 4; i++)
            r = crc_byte(r, {q_nib[16 + 2 * i + 1], q_nib[16 + 2 * i]});
        for (int k = 0; k < 32; k++) rev[k] = r[31 - k];
        check({tag, "_residue"}, rev, CRC_RESIDUE);

        check({tag, "_ifg"}, ifg_cnt, 24);
        check({tag, "_idle_data"}, idle_bad, 0);
    endtask

    vec_t vecs [6];

    initial begin
        int en_seen;
        int c;

        vecs[0] = '{kind: 0, len: 61,   exp_nib: 146};
        vecs[1] = '{kind: 1, len: 9,    exp_nib: 144};
        vecs[2] = '{kind: 2, len: 1,    exp_nib: 144};
        vecs[3] = '{kind: 3, len: 60,   exp_nib: 144};
        vecs[4] = '{kind: 3, len: 59,   exp_nib: 144};
        vecs[5] = '{kind: 3, len: 2100, exp_nib: 4120};

        // Reset for 100 ns, release away from a CLK edge.
        #100;
        check("rst_tx_en", ETH_TX_EN, 0);
        check("rst_tx_data", ETH_TX_DATA, 0);
        check("rst_busy", SENT_BUSY, 0);
        check("rst_phy_n", ETH_RST_N, 0);
        #5 RST = 1'b1;                 // t=105, next CLK rise at 110
        #1 check("phy_n_before_edge", ETH_RST_N, 0);
        #5 check("phy_n_after_edge", ETH_RST_N, 1);
        repeat (5) @(posedge CLK);

        foreach (vecs[v])
            run_frame($sformatf("vec%0d", v), vecs[v].kind, vecs[v].len,
                      vecs[v].exp_nib, 1'b0);

        // SEND_EN pulsed mid-transmission must not disturb the frame.
        run_frame("pulse", 1, 9, 144, 1'b1);

        // Reset mid-frame aborts at once and nothing resumes afterwards.
        q_nib.delete();
        for (int i = 0; i < 9; i++) begin
            @(posedge CLK); #1; SEND_EN = 1'b1; SEND_DATA = byte_of(1, i);
        end
        @(posedge CLK); #1; SEND_EN = 1'b0;
        c = 0;
        while (q_nib.size() < 20 && c < 2000) begin @(posedge CLK); c++; end
        check("abort_reach", (q_nib.size() >= 20), 1);
        @(negedge CLK); RST = 1'b0;
        #1;
        check("abort_tx_en", ETH_TX_EN, 0);
        check("abort_busy", SENT_BUSY, 0);
        check("abort_phy_n", ETH_RST_N, 0);
        @(negedge CLK); RST = 1'b1;
        en_seen = 0;
        repeat (600) begin
            @(negedge CLK);
            if (ETH_TX_EN || SENT_BUSY) en_seen++;
        end
        check("abort_no_resume", en_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule : tb_rtl8201_mii_mac
`default_nettype wire
